load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side load/store unit that sits between the single-cycle core's execute stage and the word-addressed data memory. It accepts RV32I byte, halfword and word loads and stores through a valid/ready request port. It drives the memory's clk-synchronous write / registered-read interface and returns sign- or zero-extended load data. Sub-word stores are performed as a read-modify-write sequence.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte-address width of `req_addr`.
- `DATA_WIDTH`, default 32: data width. Fixed at 32; other values are unsupported.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I funct3 (size/sign).
- `req_addr`  in  ADDR_WIDTH: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `resp_valid`  out  1: one-cycle pulse, request complete.
- `resp_rdata`  out  32: extended load data; 0 for stores.
- `resp_err`  out  1: misaligned or illegal request; qualified by `resp_valid`.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_WIDTH-2: word index, `req_addr[ADDR_WIDTH-1:2]`.
- `mem_wdata`  out  32: full word to write.
- `mem_rdata`  in  32: memory read data, valid the cycle after a read cycle (`mem_we`=0) is presented.

## Operation
- **Legal funct3 values.**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal: complete with `resp_err`=1 and make no memory access.
- **Handshake.** A request is accepted on a cycle where `req_valid && req_ready`. All request fields are latched on acceptance; the inputs are don't-care afterwards.
- **States.** IDLE, RD_ISSUE, RD_DATA, WR, RESP.
  - From IDLE on accept:
    - Error: go to RESP.
    - SW: go to WR.
    - Load, SB or SH: go to RD_ISSUE.
  - RD_ISSUE: `mem_we`=0, `mem_addr` = latched word index. Always go to RD_DATA.
  - RD_DATA, for a load: extract the byte/halfword at `addr[1:0]` from `mem_rdata`, sign- or zero-extend it, register it into `resp_rdata`, then go to RESP.
  - RD_DATA, for SB/SH: merge the low byte/half of the store data into `mem_rdata` at lane `addr[1:0]`, register the result as `mem_wdata`, then go to WR.
  - WR: `mem_we`=1 for exactly one cycle, then go to RESP.
  - RESP: `resp_valid`=1, then go to IDLE.
- **Byte lanes.** Little-endian: byte k occupies bits [8k+7:8k]; halfword at `addr[1]` occupies bits [16h+15:16h].
- **Write gating.** `mem_we` is forced to 0 in any cycle where `rst` is high. A WR state coinciding with reset therefore never writes.
- **Output holding.** `mem_addr` and `mem_wdata` hold their last value outside active states. `resp_rdata` holds until the next RD_DATA of a load, and is cleared to 0 when a store or error response is issued.

## Timing
- **Reset values** (synchronous, at the next edge with `rst`=1): state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Latency** from accept (cycle 0) to `resp_valid`:
  - Load: cycle 3.
  - SW: cycle 2; write at cycle 1.
  - SB/SH: cycle 4; read at cycle 1, write at cycle 3.
  - Error: cycle 1.
- **Throughput.** `req_ready` is low from cycle 1 through the RESP cycle, so there is no back-to-back overlap. The next accept can occur on the cycle after RESP.
- **Reset mid-operation.** Any state returns to IDLE, all latched fields are discarded, and no `resp_valid` is produced for the aborted request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]`=1 is an error response.
  - LW/SW with `addr[1:0]`≠0 is an error response.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Low address bits are forced to natural alignment: halfword clears bit 0; word clears bits [1:0].
  - The access proceeds normally; `resp_err` is asserted only for illegal funct3.

## Structure
- **Package `lsu_pkg`:** funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum typedef with its 3-bit encoding.
- **Sub-module `lsu_data_align`:** purely combinational. Provides `extract(rdata, offset, funct3)` for loads and `merge(rdata, wdata, offset, funct3)` for stores. The FSM lives in `load_store_unit`.

## Test plan
- **Word store then load.** SW addr 0x10 data 0xDEADBEEF, then LW 0x10.
  - Required: `mem_we` at accept+1 with `mem_addr`=4; load `resp_rdata`=0xDEADBEEF at accept+3.
- **Sub-word loads.** Word 0x80F17F01 at index 2; LB 0x0B, LBU 0x0B, LH 0x0A, LHU 0x0A.
  - Required: 0xFFFFFF80, 0x00000080, 0xFFFF80F1, 0x000080F1.
- **Read-modify-write.** Word 0x11223344 at index 1; SB 0x05 data 0xAB, then SH 0x06 data 0xCDEF.
  - Required: memory word 0x1122AB44, then 0xCDEFAB44; `resp_valid` at accept+4 each time.
- **Misalignment.** LW at 0x13.
  - Macro on: `resp_err`=1 at accept+1 and `mem_we` never asserts.
  - Macro off: reads index 4, no error.
- **Reset during RMW.** SB; assert `rst` in the RD_DATA cycle.
  - Required: no `mem_we` pulse, no `resp_valid`, `req_ready`=1 the next cycle, memory unchanged.
- **Illegal funct3.** Load with funct3=011.
  - Required: `resp_err`=1, `resp_rdata`=0, no memory access, regardless of macro.

Source files
------------

// File: rtl/lsu_pkg.sv
// Package shared by the load/store unit.
// Holds the RV32I funct3 codes for loads/stores, the access-size field
// encoding (funct3[1:0]) and the FSM state type.
package lsu_pkg;

  // RV32I load/store funct3 codes (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] carries the access size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_DATA  = 3'd2,
    ST_WR       = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering for the load/store unit.
//   extract: picks the byte/halfword at 'offset' out of 'rdata' and sign- or
//            zero-extends it according to 'funct3' (word passes through).
//   merge:   overlays the low byte/halfword of 'wdata' onto 'rdata' at lane
//            'offset' (word replaces everything) for read-modify-write stores.
// Ports:
//   rdata      in  32  word read from memory
//   wdata      in  32  right-aligned store data
//   offset     in  2   byte offset inside the word (already aligned for size)
//   funct3     in  3   RV32I funct3 of the access
//   load_data  out 32  extended load result
//   merge_data out 32  word to write back
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  rbyte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_en;
      logic [7:0] lane_src;

      assign rbyte[gi] = rdata[8*gi +: 8];

      // Each lane decides whether the store covers it and which store byte
      // lands there: a byte store always sources wdata[7:0], a halfword store
      // sources the low or high byte of wdata[15:0] by lane parity.
      always_comb begin
        lane_en  = 1'b0;
        lane_src = wdata[8*gi +: 8];
        case (funct3[1:0])
          SZ_BYTE: begin
            lane_en  = (offset == 2'(gi));
            lane_src = wdata[7:0];
          end
          SZ_HALF: begin
            lane_en  = (offset[1] == 1'(gi / 2));
            lane_src = wdata[8*(gi % 2) +: 8];
          end
          default: begin
            lane_en  = 1'b1;
            lane_src = wdata[8*gi +: 8];
          end
        endcase
      end

      assign merge_data[8*gi +: 8] = lane_en ? lane_src : rbyte[gi];
    end
  endgenerate

  always_comb begin
    sel_byte = rbyte[offset];
    sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a single-cycle core and a word-addressed data
// memory with clk-synchronous write and registered (1-cycle) read.
// Byte/halfword stores are done as read-modify-write; word stores write
// directly. Loads return sign/zero-extended data.
//
// Build option: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned LH/LHU/SH/LW/SW complete with resp_err and no access
//   undefined - low address bits are forced to natural alignment
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3       store flag, RV32I size/sign code
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     load result (0 for stores/errors), error flag
//   mem_we, mem_addr         memory write enable, word index
//   mem_wdata, mem_rdata     memory write word, read word (1 cycle later)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t state_reg, state_next;

  // Request fields latched on accept
  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [1:0]            off_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  err_reg;

  logic [DATA_WIDTH-1:0] resp_rdata_reg;
  logic [ADDR_WIDTH-3:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;

  logic                  accept;
  logic                  f3_illegal;
  logic                  misalign;
  logic                  req_err;
  logic                  req_is_sw;
  logic [1:0]            aligned_off;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  assign req_ready  = (state_reg == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_reg == ST_RESP);
  // A WR cycle that coincides with reset must not reach the memory.
  assign mem_we     = (state_reg == ST_WR) && !rst;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = err_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign req_is_sw  = req_we && (req_funct3 == F3_W);

  // Legal codes: loads B/H/W/BU/HU, stores B/H/W only.
  always_comb begin
    f3_illegal = 1'b1;
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_illegal = 1'b0;
      F3_BU, F3_HU:     f3_illegal = req_we;
      default:          f3_illegal = 1'b1;
    endcase
  end

  always_comb begin
    misalign    = 1'b0;
    aligned_off = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      SZ_HALF: misalign = req_addr[0];
      SZ_WORD: misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
`else
    case (req_funct3[1:0])
      SZ_HALF: aligned_off = {req_addr[1], 1'b0};
      SZ_WORD: aligned_off = 2'b00;
      default: aligned_off = req_addr[1:0];
    endcase
`endif
  end

  assign req_err = f3_illegal || misalign;

  lsu_data_align u_align (
    .rdata      (mem_rdata),
    .wdata      (wdata_reg),
    .offset     (off_reg),
    .funct3     (funct3_reg),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)        state_next = ST_RESP;
          else if (req_is_sw) state_next = ST_WR;
          else                state_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_next = ST_RD_DATA;
      // Only sub-word stores pass through RD_DATA besides loads.
      ST_RD_DATA:  state_next = we_reg ? ST_WR : ST_RESP;
      ST_WR:       state_next = ST_RESP;
      ST_RESP:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      we_reg         <= 1'b0;
      funct3_reg     <= 3'b000;
      off_reg        <= 2'b00;
      wdata_reg      <= '0;
      err_reg        <= 1'b0;
      resp_rdata_reg <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            off_reg    <= aligned_off;
            wdata_reg  <= req_wdata;
            err_reg    <= req_err;
            if (req_err) begin
              // Error response carries no data; memory outputs stay put.
              resp_rdata_reg <= '0;
            end else begin
              mem_addr_reg <= req_addr[ADDR_WIDTH-1:2];
              // A word store goes straight to WR next cycle, so its write
              // word must be in place already.
              if (req_is_sw) mem_wdata_reg <= req_wdata;
            end
          end
        end
        ST_RD_DATA: begin
          if (we_reg) mem_wdata_reg  <= merge_data;
          else        resp_rdata_reg <= load_data;
        end
        ST_WR:   resp_rdata_reg <= '0;
        ST_RESP: err_reg        <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. Contains a 64-word memory driven
// by the DUT and an independent byte-array reference of the same memory;
// expected load results, latencies and write patterns come from the byte
// model and the access rules, not from the RTL structure.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory the DUT talks to: synchronous write, registered read.
  logic [31:0] mem [64];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_en)      mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[5:0]];
  end

  // Reference memory as plain bytes, little-endian.
  logic [7:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = 6'(idx); pre_val = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[idx*4 + i] = val[8*i +: 8];
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd_o, output logic err_o);
    logic        legal, exp_err, has_read;
    int          nb, ea, exp_lat, exp_writes, exp_wr_cyc;
    logic [31:0] exp_rd;
    int          lat, wr_cnt, wr_cyc;
    logic [29:0] wr_addr, rd_addr;
    logic        ready_bad;

    legal   = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    nb      = legal ? (1 << f3[1:0]) : 1;
    exp_err = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && (int'(addr) % nb) != 0) exp_err = 1'b1;
    ea = int'(addr);
`else
    ea = int'(addr) - (int'(addr) % nb);
`endif
    exp_rd = 32'h0;
    if (!exp_err && !we) begin
      for (int i = 0; i < nb; i++) exp_rd |= 32'(ref_mem[ea + i]) << (8 * i);
      if (!f3[2] && nb < 4 && exp_rd[8*nb-1]) exp_rd |= ~((32'd1 << (8 * nb)) - 1);
    end
    has_read   = !exp_err && (!we || nb < 4);
    exp_lat    = exp_err ? 1 : (!we ? 3 : (nb == 4 ? 2 : 4));
    exp_writes = (!exp_err && we) ? 1 : 0;
    exp_wr_cyc = exp_writes == 0 ? 0 : (nb == 4 ? 1 : 3);

    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = {24'h0, addr}; req_wdata = wd;
    @(posedge clk); #1;
    // fields are don't-care after accept
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    lat = 0; wr_cnt = 0; wr_cyc = 0; wr_addr = '0; rd_addr = '0; ready_bad = 1'b0;
    rd_o = 'x; err_o = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      if (req_ready) ready_bad = 1'b1;
      if (mem_we) begin wr_cnt++; wr_cyc = c; wr_addr = mem_addr; end
      if (c == 1) rd_addr = mem_addr;
      if (resp_valid) begin
        lat = c; rd_o = resp_rdata; err_o = resp_err;
        break;
      end
      @(posedge clk); #1;
    end

    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
    chk({tag, "_rdata"}, rd_o, exp_rd);
    chk({tag, "_nwrites"}, 32'(wr_cnt), 32'(exp_writes));
    chk({tag, "_busy"}, 32'(ready_bad), 32'd0);
    if (exp_writes != 0) begin
      chk({tag, "_wrcyc"}, 32'(wr_cyc), 32'(exp_wr_cyc));
      chk({tag, "_wraddr"}, 32'(wr_addr), 32'(ea / 4));
      for (int i = 0; i < nb; i++) ref_mem[ea + i] = wd[8*i +: 8];
    end
    if (has_read) chk({tag, "_rdaddr"}, 32'(rd_addr), 32'(ea / 4));

    $display("txn %s we=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             tag, we, f3, addr, wd, rd_o, err_o, lat);
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          seen_we, seen_rv;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) preload(i, $urandom);

    // word store then load
    do_req("sw", 1'b1, F3_W, 8'h10, 32'hDEADBEEF, rd, er);
    do_req("lw", 1'b0, F3_W, 8'h10, 32'h0, rd, er);
    chk("lw_const", rd, 32'hDEADBEEF);

    // sub-word loads
    preload(2, 32'h80F17F01);
    do_req("lb", 1'b0, F3_B, 8'h0B, 32'h0, rd, er);
    chk("lb_const", rd, 32'hFFFFFF80);
    do_req("lbu", 1'b0, F3_BU, 8'h0B, 32'h0, rd, er);
    chk("lbu_const", rd, 32'h00000080);
    do_req("lh", 1'b0, F3_H, 8'h0A, 32'h0, rd, er);
    chk("lh_const", rd, 32'hFFFF80F1);
    do_req("lhu", 1'b0, F3_HU, 8'h0A, 32'h0, rd, er);
    chk("lhu_const", rd, 32'h000080F1);

    // read-modify-write
    preload(1, 32'h11223344);
    do_req("sb", 1'b1, F3_B, 8'h05, 32'h000000AB, rd, er);
    chk("sb_mem", mem[1], 32'h1122AB44);
    do_req("sh", 1'b1, F3_H, 8'h06, 32'h0000CDEF, rd, er);
    chk("sh_mem", mem[1], 32'hCDEFAB44);

    // misaligned word load
    do_req("lw_mis", 1'b0, F3_W, 8'h13, 32'h0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_const", 32'(er), 32'd1);
`else
    chk("lw_mis_const", 32'(er), 32'd0);
`endif

    // illegal funct3
    do_req("ill", 1'b0, 3'b011, 8'h20, 32'h0, rd, er);
    chk("ill_const", 32'(er), 32'd1);

    // reset in the RD_DATA cycle of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h21; req_wdata = 32'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstrmw_ready", 32'(req_ready), 32'd1);
    chk("rstrmw_mem_addr", 32'(mem_addr), 32'd0);
    chk("rstrmw_mem_wdata", mem_wdata, 32'd0);
    seen_we = 0; seen_rv = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_we) seen_we++;
      if (resp_valid) seen_rv++;
      @(posedge clk); #1;
    end
    chk("rstrmw_no_we", 32'(seen_we), 32'd0);
    chk("rstrmw_no_resp", 32'(seen_rv), 32'd0);
    $display("txn rst_in_rd_data we=%0d resp=%0d", seen_we, seen_rv);

    // reset in the WR cycle of a halfword store: the write is suppressed
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H;
    req_addr = 32'h32; req_wdata = 32'h1357;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstwr_gate", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstwr_ready", 32'(req_ready), 32'd1);
    seen_rv = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid || mem_we) seen_rv++;
      @(posedge clk); #1;
    end
    chk("rstwr_quiet", 32'(seen_rv), 32'd0);
    $display("txn rst_in_wr quiet=%0d", seen_rv);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      do_req("rnd", 1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom),
             $urandom, rd, er);
    end

    // whole memory against the byte reference
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("mem_%0d", i), mem[i],
          {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
